rgmii_tx_arbiter: RTL

RGMII_TX_ARBITER -- requirements
Module: rgmii_tx_arbiter

---
 rtl/rgmii_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rgmii_tx_arbiter.sv
// rtl/rgmii_tx_arbiter.sv - two-requester round-robin frame arbiter feeding a GMII/RGMII transmit path
//
// Purpose: picks one of two AXI-stream frame sources, prefixes each frame with
// a 7-byte preamble and SFD, forwards the bytes onto the GMII transmit bus,
// marks bad or underflowed frames with tx_er and enforces an inter-frame gap.
//
// Ports:
//   clk, rst                    byte clock, asynchronous active-high reset
//   s0_axis_* / s1_axis_*       frame sources (tdata, tvalid, tready, tlast, tuser = bad frame)
//   gmii_txd/tx_en/tx_er        registered transmit bus toward the PHY adapter
//   grant                       registered index of the current/last owner (1 after reset)
//   frame_done, frame_error     registered single-cycle status pulses

module rgmii_tx_arbiter #(
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic       s0_axis_tuser,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  input  logic       s1_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       grant,
  output logic       frame_done,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    IFG
  } state_t;

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       grant_d;
  logic [7:0] txd_d;
  logic       tx_en_d, tx_er_d, done_d, error_d;

  // Mux of the granted source.
  logic [7:0] sel_data;
  logic       sel_valid, sel_last, sel_user;

  assign sel_data  = grant ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_valid = grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last  = grant ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_user  = grant ? s1_axis_tuser  : s0_axis_tuser;

  // DATA is entered on the edge that launches the SFD, so tready is already
  // high while the SFD is on the wire and the first byte lands right after it.
  logic accepting;
  assign accepting      = (state == DATA) || (state == DROP);
  assign s0_axis_tready = accepting && !grant;
  assign s1_axis_tready = accepting &&  grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      grant       <= 1'b1;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      grant       <= grant_d;
      gmii_txd    <= txd_d;
      gmii_tx_en  <= tx_en_d;
      gmii_tx_er  <= tx_er_d;
      frame_done  <= done_d;
      frame_error <= error_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant_d = grant;
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;

    case (state)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d = PREAMBLE;
          cnt_d   = 8'd0;
          // Contention goes to whichever port did not own the last frame.
          if (s0_axis_tvalid && s1_axis_tvalid) begin
            grant_d = !grant;
          end else begin
            grant_d = s1_axis_tvalid;
          end
        end
      end

      PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt == 8'd7) begin
          txd_d   = 8'hD5;
          state_d = DATA;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt + 8'd1;
        end
      end

      DATA: begin
        tx_en_d = 1'b1;
        if (sel_valid) begin
          txd_d = sel_data;
          if (sel_last) begin
            tx_er_d = sel_user;
            done_d  = !sel_user;
            error_d = sel_user;
            state_d = IFG;
            cnt_d   = 8'd0;
          end
        end else begin
          // Source ran dry mid-frame: poison the frame with one error byte
          // and silently drain whatever is left of it.
          tx_er_d = 1'b1;
          error_d = 1'b1;
          state_d = DROP;
        end
      end

      DROP: begin
        if (sel_valid && sel_last) begin
          state_d = IFG;
          cnt_d   = 8'd0;
        end
      end

      IFG: begin
        if (cnt >= IFG_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
